// File: rtl/obstacle_if.sv
// Control/status bundle between the obstacle controller and its surroundings.
// master drives the frame/start/collision inputs; slave is the controller side.
interface obstacle_if;
  logic       i_frame_tick;
  logic       i_start;
  logic       i_collision;
  logic [9:0] o_xpos;
  logic       o_active;
  logic [3:0] o_speed;
  logic       o_pass;
  logic [1:0] o_state;

  modport master (
    output i_frame_tick, i_start, i_collision,
    input  o_xpos, o_active, o_speed, o_pass, o_state
  );

  modport slave (
    input  i_frame_tick, i_start, i_collision,
    output o_xpos, o_active, o_speed, o_pass, o_state
  );
endinterface

// File: rtl/obstacle_ctrl.sv
// Per-frame obstacle motion controller: moves one obstacle leftward per frame,
// inserts LFSR-randomised gaps, ramps speed over time and freezes on collision.
//
// state | meaning
// IDLE  | no game running, obstacle hidden at spawn position
// GAP   | waiting out the random gap before the next obstacle spawns
// MOVE  | obstacle visible and advancing by o_speed each frame
// HALT  | collision seen, everything frozen until restart
module obstacle_ctrl #(
  parameter int unsigned SPAWN_X    = 640,
  parameter int unsigned MIN_GAP    = 16,
  parameter int unsigned SPEED_INIT = 1,
  parameter int unsigned SPEED_MAX  = 8,
  parameter int unsigned SPEED_STEP = 256,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  obstacle_if.slave  bus
);

  localparam int GAP_W = $clog2(MIN_GAP + 16);
  localparam int FC_W  = $clog2(SPEED_STEP);

  localparam logic [9:0]       SPAWN    = 10'(SPAWN_X);
  localparam logic [3:0]       SPD_INIT = 4'(SPEED_INIT);
  localparam logic [3:0]       SPD_MAX  = 4'(SPEED_MAX);
  localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(SPEED_STEP - 1);
  localparam logic [GAP_W-1:0] GAP_MIN  = GAP_W'(MIN_GAP);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    MOVE = 2'd2,
    HALT = 2'd3
  } state_t;

  state_t           state_q,  state_d;
  logic [9:0]       xpos_q,   xpos_d;
  logic             active_q, active_d;
  logic [3:0]       speed_q,  speed_d;
  logic             pass_q,   pass_d;
  logic [GAP_W-1:0] gap_q,    gap_d;
  logic [FC_W-1:0]  fc_q,     fc_d;
  logic [7:0]       lfsr_q,   lfsr_d;

  logic [7:0]       lfsr_adv;
  logic [GAP_W-1:0] gap_load;
  logic [3:0]       speed_inc;
  logic [9:0]       speed_ext;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      xpos_q   <= SPAWN;
      active_q <= 1'b0;
      speed_q  <= SPD_INIT;
      pass_q   <= 1'b0;
      gap_q    <= '0;
      fc_q     <= '0;
      lfsr_q   <= LFSR_SEED;
    end else begin
      state_q  <= state_d;
      xpos_q   <= xpos_d;
      active_q <= active_d;
      speed_q  <= speed_d;
      pass_q   <= pass_d;
      gap_q    <= gap_d;
      fc_q     <= fc_d;
      lfsr_q   <= lfsr_d;
    end
  end

  // Gap length is drawn from the LFSR value before this cycle's advance.
  assign lfsr_adv  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign gap_load  = GAP_MIN + GAP_W'(lfsr_q[3:0]);
  assign speed_inc = (speed_q >= SPD_MAX) ? speed_q : speed_q + 4'd1;
  assign speed_ext = {6'd0, speed_q};

  always_comb begin
    state_d  = state_q;
    xpos_d   = xpos_q;
    active_d = active_q;
    speed_d  = speed_q;
    pass_d   = 1'b0;
    gap_d    = gap_q;
    fc_d     = fc_q;
    lfsr_d   = bus.i_frame_tick ? lfsr_adv : lfsr_q;

    case (state_q)
      IDLE: begin
        if (bus.i_start) begin
          state_d  = GAP;
          gap_d    = gap_load;
          speed_d  = SPD_INIT;
          fc_d     = '0;
          xpos_d   = SPAWN;
          active_d = 1'b0;
        end
      end

      GAP, MOVE: begin
        // Collision wins over the tick: freeze without moving or ramping.
        if (bus.i_collision) begin
          state_d = HALT;
        end else if (bus.i_frame_tick) begin
          if (fc_q == FC_LAST) begin
            fc_d    = '0;
            speed_d = speed_inc;
          end else begin
            fc_d = fc_q + 1'b1;
          end

          if (state_q == GAP) begin
            if (gap_q == '0) begin
              state_d  = MOVE;
              xpos_d   = SPAWN;
              active_d = 1'b1;
            end else begin
              gap_d = gap_q - 1'b1;
            end
          end else if (xpos_q <= speed_ext) begin
            state_d  = GAP;
            active_d = 1'b0;
            pass_d   = 1'b1;
            gap_d    = gap_load;
          end else begin
            xpos_d = xpos_q - speed_ext;
          end
        end
      end

      HALT: begin
        if (bus.i_start) begin
          state_d  = IDLE;
          xpos_d   = SPAWN;
          active_d = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.o_xpos   = xpos_q;
  assign bus.o_active = active_q;
  assign bus.o_speed  = speed_q;
  assign bus.o_pass   = pass_q;
  assign bus.o_state  = state_q;

endmodule
